// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Each frame is captured, launched, awaited with a timeout, and followed by an idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       err_clr,
    output logic [15:0]                frames_sent
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_rr;
    logic [ID_W-1:0]      r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_start;
    logic [7:0]           r_data;
    logic                 r_err;
    logic [15:0]          r_frames_sent;
    logic [TO_W-1:0]      r_to_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic [ID_W-1:0]      w_sel;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_sel_1h;
    logic [7:0]           w_sel_data;
    logic [ID_W-1:0]      w_next_rr;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Scan from the highest offset down so the nearest valid index at/after the pointer wins.
    always_comb begin
        w_sel = r_rr;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(r_rr, k)]) begin
                w_sel = rr_index(r_rr, k);
                w_any = 1'b1;
            end
        end
    end

    assign w_sel_1h   = NUM_REQ'(1) << w_sel;
    assign w_sel_data = req_data[{w_sel, 3'b000} +: 8];
    assign w_next_rr  = (r_grant == ID_LAST) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_grant       <= '0;
            r_ack         <= '0;
            r_start       <= 1'b0;
            r_data        <= '0;
            r_err         <= 1'b0;
            r_frames_sent <= '0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            if (err_clr) r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any && !tx_busy) begin
                        r_grant <= w_sel;
                        r_data  <= w_sel_data;
                        r_start <= 1'b1;
                        r_ack   <= w_sel_1h;
                        r_state <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_DONE;
                end

                // r_to_cnt trails the cycles since tx_start by one, so the abort
                // decision falls exactly TIMEOUT_CYCLES cycles after the start pulse.
                S_WAIT_DONE: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (tx_done) begin
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_rr          <= w_next_rr;
                        r_gap_cnt     <= '0;
                        r_state       <= S_GAP;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err     <= 1'b1;
                        r_rr      <= w_next_rr;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack     = r_ack;
    assign tx_start    = r_start;
    assign tx_data     = r_data;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_err;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, busy hold-off, async reset,
// round-robin order, timeout, done-vs-timeout tie and frame counter wrap.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 16;
    localparam int TMO     = 4000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;
    logic                 err_clr;
    logic [15:0]          frames_sent;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] g_gid;
    logic [7:0] g_dat;
    logic [3:0] g_ack;
    logic [3:0] g_ack2;
    logic       g_start2;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("start_within_limit", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_limit", 32'(n < 100), 32'd1);
    endtask

    // Captures the launch cycle, then answers with tx_done in cycle done_dly after it.
    task automatic run_frame(input int done_dly, input logic [3:0] valid_after);
        int n;
        wait_start(n);
        g_gid     = grant_id;
        g_dat     = tx_data;
        g_ack     = req_ack;
        req_valid = valid_after;
        @(negedge clk);
        g_start2 = tx_start;
        g_ack2   = req_ack;
        repeat (done_dly - 2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        tx_done   = 1'b0;
        tx_busy   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int first;
        int starts;
        int exp_id;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_start",    32'(tx_start),    32'd0);
        check("rst_req_ack",     32'(req_ack),     32'd0);
        check("rst_tx_data",     32'(tx_data),     32'd0);
        check("rst_grant_id",    32'(grant_id),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from source 2.
        req_valid = 4'b0100;
        run_frame(50, 4'b0000);
        check("t1_grant",      32'(g_gid),       32'd2);
        check("t1_data",       32'(g_dat),       32'hA5);
        check("t1_ack",        32'(g_ack),       32'b0100);
        check("t1_start_len",  32'(g_start2),    32'd0);
        check("t1_ack_len",    32'(g_ack2),      32'd0);
        check("t1_frames",     32'(frames_sent), 32'd1);
        check("t1_busy_gap",   32'(busy),        32'd1);
        wait_idle(n);
        check("t1_gap_len",    n,                GAP);

        // Stray tx_done while idle.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("stray_done_frames", 32'(frames_sent), 32'd1);
        check("stray_done_busy",   32'(busy),        32'd0);

        // tx_busy holds off arbitration.
        tx_busy   = 1'b1;
        req_valid = 4'b0010;
        starts    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        check("busy_hold_starts", starts,      0);
        check("busy_hold_idle",   32'(busy),   32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_release_start", 32'(tx_start), 32'd1);
        check("busy_release_grant", 32'(grant_id), 32'd1);
        check("busy_release_ack",   32'(req_ack),  32'b0010);
        req_valid = '0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_frames", 32'(frames_sent), 32'd2);
        wait_idle(n);

        // Asynchronous reset in the middle of WAIT_DONE.
        req_valid = 4'b0100;
        wait_start(n);
        req_valid = '0;
        repeat (5) @(negedge clk);
        check("arst_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_tx_start", 32'(tx_start),    32'd0);
        check("arst_req_ack",  32'(req_ack),     32'd0);
        check("arst_tx_data",  32'(tx_data),     32'd0);
        check("arst_grant",    32'(grant_id),    32'd0);
        check("arst_busy",     32'(busy),        32'd0);
        check("arst_frames",   32'(frames_sent), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1000;
        run_frame(5, 4'b0000);
        check("post_rst_grant",  32'(g_gid),       32'd3);
        check("post_rst_data",   32'(g_dat),       32'h44);
        check("post_rst_ack",    32'(g_ack),       32'b1000);
        check("post_rst_frames", 32'(frames_sent), 32'd1);
        wait_idle(n);

        // Round robin with every source continuously valid.
        do_reset();
        req_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            run_frame(3, (i == 7) ? 4'h0 : 4'hF);
            exp_id = i % 4;
            check($sformatf("rr%0d_grant", i), 32'(g_gid),  exp_id);
            check($sformatf("rr%0d_ack", i),   32'(g_ack),  32'(4'b0001 << exp_id));
            check($sformatf("rr%0d_data", i),  32'(g_dat),  32'(8'(8'hA1 + 8'h11 * exp_id)));
            check($sformatf("rr%0d_ack_len", i), 32'(g_ack2), 32'd0);
            wait_idle(n);
        end
        check("rr_frames", 32'(frames_sent), 32'd8);

        // Withheld tx_done: timeout, then the next requester is served.
        req_valid = 4'b0011;
        wait_start(n);
        check("tmo_grant", 32'(grant_id), 32'd0);
        req_valid = 4'b0010;
        k     = 0;
        first = -1;
        while (k < TMO + 20 && first < 0) begin
            @(negedge clk);
            k++;
            if (timeout_err === 1'b1) first = k;
        end
        check("tmo_cycles", first,             TMO);
        check("tmo_frames", 32'(frames_sent), 32'd8);
        wait_idle(n);
        run_frame(4, 4'b0000);
        check("tmo_next_grant", 32'(g_gid),       32'd1);
        wait_idle(n);
        check("tmo_next_frames", 32'(frames_sent), 32'd9);
        check("tmo_sticky",      32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);

        // tx_done on the last cycle before the timeout fires: done wins.
        req_valid = 4'b0001;
        wait_start(n);
        check("tie_grant_wrap", 32'(grant_id), 32'd0);
        req_valid = '0;
        repeat (TMO - 1) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("tie_no_err", 32'(timeout_err), 32'd0);
        check("tie_frames", 32'(frames_sent), 32'd10);
        check("tie_busy",   32'(busy),        32'd1);
        wait_idle(n);
        @(negedge clk);
        check("tie_no_err_late", 32'(timeout_err), 32'd0);

        // Frame counter wrap from 0xFFFF, counter preloaded to skip 65535 frames.
        force dut.r_frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut.r_frames_sent;
        req_valid = 4'b0100;
        run_frame(3, 4'b0000);
        check("wrap_frames", 32'(frames_sent), 32'd0);
        wait_idle(n);
        req_valid = 4'b1000;
        run_frame(3, 4'b0000);
        check("wrap_next_frames", 32'(frames_sent), 32'd1);
        wait_idle(n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
